// File: rtl/instb_ctrl.sv
// Instruction-buffer SRAM controller: packs host words into byte-enabled line
// writes on port A and streams burst line fetches from port B through a 3-entry buffer.
module instb_ctrl #(
    parameter  int AW  = 12,
    parameter  int DW  = 128,
    parameter  int HW  = 32,
    localparam int BW  = DW / 8,
    localparam int WPL = DW / HW,
    localparam int WS  = $clog2(WPL),
    localparam int SB  = HW / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [AW+WS-1:0]  host_wr_addr,
    input  logic [HW-1:0]     host_wr_data,
    input  logic [SB-1:0]     host_wr_strb,
    input  logic              fetch_start,
    input  logic [AW-1:0]     fetch_base,
    input  logic [AW:0]       fetch_len,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DW-1:0]     ins_data,
    output logic [AW-1:0]     ins_addr,
    output logic              sram_ena,
    output logic              sram_wea,
    output logic [BW-1:0]     sram_be,
    output logic [AW-1:0]     sram_addra,
    output logic [DW-1:0]     sram_dina,
    output logic              sram_enb,
    output logic [AW-1:0]     sram_addrb,
    input  logic [DW-1:0]     sram_doutb
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam int         NBUF    = 3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [AW:0]   popcnt_q, popcnt_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_addr_q, inflight_addr_d;
    logic [1:0]    occ_q, occ_d;
    logic [1:0]    head_q, head_d;
    logic [1:0]    tail_q, tail_d;
    logic [DW-1:0] buf_data_q [NBUF];
    logic [AW-1:0] buf_addr_q [NBUF];

    logic          wr_ready_q;
    logic          wr_act_q, wr_act_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [BW-1:0] wr_be_q, wr_be_d;

    logic wr_accept;
    logic hazard;
    logic issue;
    logic pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(NBUF - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin : write_stage
        wr_accept = host_wr_valid && wr_ready_q;
        wr_act_d  = wr_accept;
        wr_addr_d = '0;
        wr_data_d = '0;
        wr_be_d   = '0;
        if (wr_accept) begin
            wr_addr_d = host_wr_addr[AW+WS-1:WS];
            wr_data_d = {WPL{host_wr_data}};
            wr_be_d[host_wr_addr[WS-1:0]*SB +: SB] = host_wr_strb;
        end
    end

    always_comb begin : fetch_ctrl
        // A read of the line being written this cycle would return stale data.
        hazard = wr_act_q && (wr_addr_q == rd_addr_q);
        issue  = (state_q == S_FETCH) && (remaining_q != '0)
                 && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3) && !hazard;
        pop    = (occ_q != 2'd0) && ins_ready;

        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        remaining_d     = remaining_q;
        popcnt_d        = popcnt_q;
        inflight_d      = issue;
        inflight_addr_d = rd_addr_q;
        occ_d           = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        tail_d          = inflight_q ? ptr_inc(tail_q) : tail_q;
        head_d          = pop ? ptr_inc(head_q) : head_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    if (fetch_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_FETCH;
                        rd_addr_d   = fetch_base;
                        remaining_d = fetch_len;
                        popcnt_d    = fetch_len;
                    end
                end
            end
            S_FETCH: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + AW'(1);
                    remaining_d = remaining_q - (AW+1)'(1);
                end
                if (pop) begin
                    popcnt_d = popcnt_q - (AW+1)'(1);
                    if (popcnt_q == (AW+1)'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rd_addr_q       <= '0;
            remaining_q     <= '0;
            popcnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            occ_q           <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            wr_ready_q      <= 1'b0;
            wr_act_q        <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_be_q         <= '0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            remaining_q     <= remaining_d;
            popcnt_q        <= popcnt_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            occ_q           <= occ_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            wr_ready_q      <= 1'b1;
            wr_act_q        <= wr_act_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_be_q         <= wr_be_d;
        end
    end

    // NOTE: buffer storage is not reset; occupancy is, and the outputs are gated by ins_valid.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            buf_data_q[tail_q] <= sram_doutb;
            buf_addr_q[tail_q] <= inflight_addr_q;
        end
    end

    assign host_wr_ready = wr_ready_q;
    assign sram_ena      = wr_act_q;
    assign sram_wea      = wr_act_q;
    assign sram_be       = wr_be_q;
    assign sram_addra    = wr_addr_q;
    assign sram_dina     = wr_data_q;
    assign sram_enb      = issue;
    assign sram_addrb    = issue ? rd_addr_q : '0;
    assign fetch_busy    = (state_q != S_IDLE);
    assign fetch_done    = (state_q == S_DONE);
    assign ins_valid     = (occ_q != 2'd0);
    assign ins_data      = ins_valid ? buf_data_q[head_q] : '0;
    assign ins_addr      = ins_valid ? buf_addr_q[head_q] : '0;

endmodule

// File: tb/tb_instb_ctrl.sv
// Self-checking bench for instb_ctrl: SRAM model plus a line-array reference that
// predicts every fetched beat, its timing, and the port-A write encoding.
module tb_instb_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         host_wr_valid;
    logic         host_wr_ready;
    logic [13:0]  host_wr_addr;
    logic [31:0]  host_wr_data;
    logic [3:0]   host_wr_strb;
    logic         fetch_start;
    logic [11:0]  fetch_base;
    logic [12:0]  fetch_len;
    logic         fetch_busy;
    logic         fetch_done;
    logic         ins_valid;
    logic         ins_ready;
    logic [127:0] ins_data;
    logic [11:0]  ins_addr;
    logic         sram_ena;
    logic         sram_wea;
    logic [15:0]  sram_be;
    logic [11:0]  sram_addra;
    logic [127:0] sram_dina;
    logic         sram_enb;
    logic [11:0]  sram_addrb;
    logic [127:0] sram_doutb;

    int checks = 0;
    int errors = 0;

    logic [127:0] sram_mem [4096];
    logic [127:0] ref_mem  [4096];
    bit           mem_loaded = 1'b0;

    instb_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_wr_strb  (host_wr_strb),
        .fetch_start   (fetch_start),
        .fetch_base    (fetch_base),
        .fetch_len     (fetch_len),
        .fetch_busy    (fetch_busy),
        .fetch_done    (fetch_done),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ins_data      (ins_data),
        .ins_addr      (ins_addr),
        .sram_ena      (sram_ena),
        .sram_wea      (sram_wea),
        .sram_be       (sram_be),
        .sram_addra    (sram_addra),
        .sram_dina     (sram_dina),
        .sram_enb      (sram_enb),
        .sram_addrb    (sram_addrb),
        .sram_doutb    (sram_doutb)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] init_line(input int i);
        return {32'(i) * 32'h9E3779B1, 32'(i) ^ 32'h5A5A5A5A, 32'(i) * 32'h85EBCA6B, ~32'(i)};
    endfunction

    // Simple-dual-port SRAM: registered read on port B, byte-enabled write on port A.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) sram_mem[i] = init_line(i);
            mem_loaded = 1'b1;
        end
        if (sram_enb) sram_doutb <= sram_mem[sram_addrb];
        if (sram_ena && sram_wea)
            for (int b = 0; b < 16; b++)
                if (sram_be[b]) sram_mem[sram_addra][b*8 +: 8] = sram_dina[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [319:0] all_outs();
        return 320'({host_wr_ready, fetch_busy, fetch_done, ins_valid, ins_data, ins_addr,
                     sram_ena, sram_wea, sram_be, sram_addra, sram_dina, sram_enb, sram_addrb});
    endfunction

    task automatic ref_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s[k]) ref_mem[a[13:2]][int'(a[1:0])*32 + k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic host_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [15:0] exp_be;
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        host_wr_strb  = s;
        tick();
        exp_be = 16'(s) << (4 * a[1:0]);
        check("wr_port_a", 320'({sram_ena, sram_wea, sram_addra, sram_be, sram_dina}),
              320'({1'b1, 1'b1, a[13:2], exp_be, {4{d}}}));
        ref_write(a, d, s);
        host_wr_valid = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready toggles; 2: random ready plus ignored start noise.
    task automatic run_fetch(input logic [11:0] base, input int len, input int mode,
                             input bit wr_en, input logic [13:0] wr_a,
                             input logic [31:0] wr_d, input logic [3:0] wr_s);
        logic [11:0]  exp_addr [$];
        logic [127:0] exp_data [$];
        logic [11:0]  ea;
        logic [127:0] hold_data;
        logic [11:0]  hold_addr;
        int issued, popped, first_enb, first_valid, done_cyc, last_pop, max_out, exp_first_enb, limit;
        bit rdy, busy_bad, unstable, extra, hold;
        issued = 0; popped = 0; first_enb = -1; first_valid = -1; done_cyc = -1;
        last_pop = 0; max_out = 0; busy_bad = 0; unstable = 0; extra = 0; hold = 0;
        hold_data = '0; hold_addr = '0;
        limit = 4 * len + 20;

        fetch_start = 1'b1;
        fetch_base  = base;
        fetch_len   = 13'(len);
        ins_ready   = 1'b0;
        if (wr_en) begin
            host_wr_valid = 1'b1;
            host_wr_addr  = wr_a;
            host_wr_data  = wr_d;
            host_wr_strb  = wr_s;
            ref_write(wr_a, wr_d, wr_s);
        end
        for (int i = 0; i < len; i++) begin
            ea = base + 12'(i);
            exp_addr.push_back(ea);
            exp_data.push_back(ref_mem[ea]);
        end
        exp_first_enb = (wr_en && wr_a[13:2] == base) ? 2 : 1;

        for (int c = 1; c <= limit && done_cyc < 0; c++) begin
            tick();
            host_wr_valid = 1'b0;
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (c % 2 == 1);
            else                rdy = 1'($urandom_range(0, 1));
            ins_ready = rdy;
            if (mode == 2) begin
                fetch_start = 1'($urandom_range(0, 1));
                fetch_base  = 12'($urandom);
                fetch_len   = 13'($urandom);
            end else begin
                fetch_start = 1'b0;
            end

            if (sram_enb) begin
                if (first_enb < 0) first_enb = c;
                ea = base + 12'(issued);
                check("issue_addr", 320'(sram_addrb), 320'(ea));
                issued++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (!fetch_busy) busy_bad = 1'b1;
            if (hold && (!ins_valid || ins_data !== hold_data || ins_addr !== hold_addr)) unstable = 1'b1;
            if (ins_valid && first_valid < 0) first_valid = c;
            if (ins_valid && rdy) begin
                if (exp_addr.size() == 0) begin
                    extra = 1'b1;
                end else begin
                    check("beat_addr", 320'(ins_addr), 320'(exp_addr.pop_front()));
                    check("beat_data", 320'(ins_data), 320'(exp_data.pop_front()));
                end
                popped++;
                last_pop = c;
            end
            hold      = ins_valid && !rdy;
            hold_data = ins_data;
            hold_addr = ins_addr;
            if (fetch_done) done_cyc = c;
        end

        fetch_start = 1'b0;
        check("done_after_last_pop", 320'(done_cyc), 320'((len == 0) ? 1 : last_pop + 1));
        check("lines_issued", 320'(issued), 320'(len));
        check("beats_popped", 320'(popped), 320'(len));
        check("extra_unstable_idle", 320'({extra, unstable, busy_bad}), 320'(3'b000));
        check("outstanding_over_3", 320'(max_out > 3), 320'(1'b0));
        if (len > 0) begin
            check("first_issue_cycle", 320'(first_enb), 320'(exp_first_enb));
            check("first_valid_cycle", 320'(first_valid), 320'(exp_first_enb + 2));
        end
        if (mode == 0)
            check("done_cycle", 320'(done_cyc), 320'((len == 0) ? 1 : exp_first_enb + len + 2));
        tick();
        check("idle_after_done", 320'({fetch_done, fetch_busy}), 320'(2'b00));
    endtask

    initial begin
        logic [11:0] rb;
        int          rn;
        int          seen;
        bit          bad;

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_line(i);
        rst           = 1'b1;
        host_wr_valid = 1'b1;
        host_wr_addr  = 14'h2A5;
        host_wr_data  = 32'h12345678;
        host_wr_strb  = 4'hF;
        fetch_start   = 1'b1;
        fetch_base    = 12'h010;
        fetch_len     = 13'd3;
        ins_ready     = 1'b1;

        tick();
        tick();
        check("reset_outputs", all_outs(), 320'(0));
        rst           = 1'b0;
        host_wr_valid = 1'b0;
        fetch_start   = 1'b0;
        tick();
        check("ready_after_reset", 320'({host_wr_ready, fetch_busy, ins_valid, sram_ena}), 320'(4'b1000));

        host_write(14'h001, 32'hDEADBEEF, 4'hF);
        check("wr_be_line0_word1", 320'(sram_be), 320'(16'h00F0));
        tick();
        check("wr_idle", 320'({sram_ena, sram_wea, sram_be}), 320'(0));

        for (int l = 0; l < 8; l++)
            for (int w = 0; w < 4; w++)
                host_write({12'(l), 2'(w)}, $urandom, 4'hF);
        host_write({12'hFFE, 2'd3}, $urandom, 4'($urandom));
        host_write({12'hFFF, 2'd0}, $urandom, 4'($urandom));
        host_write({12'h001, 2'd2}, $urandom, 4'h0);

        run_fetch(12'h000, 8, 0, 1'b0, '0, '0, '0);
        run_fetch(12'h000, 8, 1, 1'b0, '0, '0, '0);
        run_fetch(12'hFFE, 4, 0, 1'b0, '0, '0, '0);
        run_fetch(12'h100, 0, 0, 1'b0, '0, '0, '0);
        run_fetch(12'h005, 1, 0, 1'b1, {12'h005, 2'd2}, 32'hCAFEF00D, 4'hF);

        // Reset after three beats of a burst, with a host write offered in the reset cycle.
        fetch_start = 1'b1;
        fetch_base  = 12'h040;
        fetch_len   = 13'd8;
        ins_ready   = 1'b1;
        seen = 0;
        for (int c = 1; c <= 20 && seen < 3; c++) begin
            tick();
            fetch_start = 1'b0;
            if (ins_valid) seen++;
        end
        tick();
        rst           = 1'b1;
        host_wr_valid = 1'b1;
        host_wr_addr  = {12'h050, 2'd1};
        host_wr_data  = 32'h0BADF00D;
        host_wr_strb  = 4'hF;
        tick();
        rst           = 1'b0;
        host_wr_valid = 1'b0;
        check("reset_mid_burst_outputs", all_outs(), 320'(0));
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (fetch_done || ins_valid || sram_enb || sram_ena) bad = 1'b1;
        end
        check("quiet_after_reset", 320'(bad), 320'(1'b0));
        run_fetch(12'h040, 8, 0, 1'b0, '0, '0, '0);
        run_fetch(12'h050, 2, 1, 1'b0, '0, '0, '0);

        for (int it = 0; it < 6; it++) begin
            rb = 12'($urandom);
            rn = $urandom_range(1, 12);
            for (int k = 0; k < 3; k++)
                host_write({rb + 12'($urandom_range(0, 11)), 2'($urandom)}, $urandom, 4'($urandom));
            run_fetch(rb, rn, 2, 1'($urandom_range(0, 1)),
                      {rb + 12'($urandom_range(0, 1)), 2'($urandom)}, $urandom, 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instb_ctrl.md
Name: instb_ctrl

Overview:
- Controller for the instruction-buffer simple-dual-port SRAM (AW=12, DW=128, byte-enabled write port A, read port B).
- Packs 32-bit host load writes into byte-enabled 128-bit line writes on port A.
- Sequences burst line fetches on port B and absorbs the 1-cycle SRAM read latency with a 3-entry output buffer behind a valid/ready interface.
- Sits between the host/DMA load path and the NPU instruction decoder.

Parameters:
AW, 12, SRAM line-address width (depth 2**AW lines)
DW, 128, SRAM line width; BW=DW/8 byte enables
HW, 32, host word width; WPL=DW/HW=4 words per line, WS=log2(WPL)=2

Ports:
clk  in  1  single clock for all logic and both SRAM ports
rst  in  1  synchronous, active-high reset
host_wr_valid  in  1  host write request
host_wr_ready  out  1  host write accept
host_wr_addr  in  AW+WS  word address; [AW+WS-1:WS]=line, [WS-1:0]=word select
host_wr_data  in  HW  write data
host_wr_strb  in  HW/8  byte strobes for the word
fetch_start  in  1  start pulse; sampled only in IDLE
fetch_base  in  AW  first line address
fetch_len  in  AW+1  number of lines to fetch (0..2**AW)
fetch_busy  out  1  high whenever state is not IDLE
fetch_done  out  1  one-cycle completion pulse
ins_valid  out  1  output line valid
ins_ready  in  1  consumer accept
ins_data  out  DW  fetched line
ins_addr  out  AW  line address of ins_data
sram_ena  out  1  port A enable
sram_wea  out  1  port A write enable
sram_be  out  BW  port A byte enables
sram_addra  out  AW  port A address
sram_dina  out  DW  port A data
sram_enb  out  1  port B enable
sram_addrb  out  AW  port B address
sram_doutb  in  DW  port B data, valid the cycle after sram_enb

Behaviour:

Reset:
- On rst (sync, active-high), all outputs are 0; state=IDLE; buffer is emptied; in-flight flag is cleared.
- Reset mid-fetch abandons the burst with no fetch_done.
- A write staged in the reset cycle is dropped.

Write path (1-stage registered):
- host_wr_ready=1 every cycle after reset.
- An accepted write appears one cycle later with sram_ena=sram_wea=1 and sram_addra=line.
- sram_dina = host_wr_data replicated WPL times.
- sram_be = host_wr_strb << (4*word_sel); all other bits 0.
- A strb=0 write still pulses sram_ena/sram_wea with be=0.
- With no accepted write, sram_ena=sram_wea=0 and sram_be=0.

Fetch FSM:
- IDLE:
  - fetch_start=1 and fetch_len=0 -> DONE.
  - fetch_start=1 and fetch_len>0 -> load rd_addr=fetch_base, remaining=fetch_len, popcnt=fetch_len; go to FETCH.
- FETCH (issue rule): issue when remaining>0, occ+inflight<3, and no hazard.
  - Issue drives sram_enb=1 and sram_addrb=rd_addr.
  - Issue updates: rd_addr+=1 (mod 2**AW, wraps 4095->0), remaining-=1.
  - Otherwise sram_enb=0.
  - occ counts only buffer entries (0..3); an entry written and popped in the same cycle leaves occ unchanged.
- FETCH (capture): the cycle after an issue, sram_doutb and its address are written into the buffer.
- FETCH (completion): each ins_valid&ins_ready decrements popcnt; when the final pop occurs -> DONE.
- DONE: fetch_done=1 for exactly one cycle -> IDLE.
- fetch_start is ignored outside IDLE.

Hazard:
- Condition: a staged port-A write is active this cycle with sram_addra==rd_addr.
- Response: suppress the issue for that cycle. The read issues the next cycle and returns the new data.

Output:
- ins_valid = occ>0; ins_data/ins_addr = head entry; in-order.
- Data is held stable while ins_valid&!ins_ready.

Timing:
- Latency: start sampled cycle 0; first sram_enb cycle 1; capture cycle 2; ins_valid cycle 3.
- Throughput is 1 line/cycle with ins_ready held high.

Test Plan:
- Host writes addr=0x001 (line 0, word 1), data=0xDEADBEEF, strb=0xF -> next cycle: sram_addra=0, sram_be=0x00F0, sram_dina=0xDEADBEEF x4, sram_wea=1.
- Preload lines 0..7; fetch_start base=0, len=8, ins_ready=1 -> ins_valid first at cycle 3; 8 consecutive beats with ins_addr 0..7; fetch_done pulses at cycle 11; fetch_busy is 0 at cycle 12.
- Same burst with ins_ready toggling 1/0 each cycle -> no loss or duplication; occ+inflight never exceeds 3; sram_enb stalls while the buffer is full.
- fetch_base=0xFFE, len=4 -> sram_addrb sequence FFE, FFF, 000, 001; fetch_len=0 -> fetch_done pulses 1 cycle after start, no sram_enb.
- Fetch base=5, len=1 while host write to line 5 is staged in the same cycle -> the issue slips one cycle; ins_data equals the newly written line.
- Assert rst mid-burst (after 3 beats) -> all outputs 0 next cycle; no fetch_done; a new fetch_start afterwards works normally.
